accum_rd_ctrl: RTL

Drain controller for the accumulator buffer. After the systolic array finishes a tile, it reads accumulator rows 0..num_row-1 in order and streams each row to the output memory writer over a valid/ready handshake. It is the read-side counterpart of the compute controller, which writes those rows while `sys_en_out` is high. A 2-entry buffer absorbs the 1-cycle accumulator read latency and output back-pressure, so rows move at one per cycle while `out_ready` stays high.

---
 rtl/accum_rd_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/accum_rd_ctrl.sv
// accum_rd_ctrl: drains accumulator rows to the output writer over a valid/ready handshake
module accum_rd_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int SYS_COL = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic [DATA_WIDTH-1:0] num_row_in,
  input  logic [ADDR_WIDTH-1:0] out_base_addr,
  output logic accum_rd_en,
  output logic [ADDR_WIDTH-1:0] accum_rd_addr,
  input  logic [SYS_COL*ACC_WIDTH-1:0] accum_rd_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [SYS_COL*ACC_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic busy,
  output logic done
);
  localparam int W = SYS_COL * ACC_WIDTH;
  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] num_q, base_q, rd_idx, wr_idx, addr1, new_addr, num_in;
  logic [W-1:0] data1;
  logic [1:0] occ;
  logic [2:0] credit;
  logic inflight, pop, load_head, flush_empty;
  assign num_in = ADDR_WIDTH'(num_row_in);
  assign pop = out_valid & out_ready;
  assign credit = 3'(occ) + 3'(inflight) - 3'(pop);
  assign accum_rd_en = state == READ && rd_idx < num_q && credit < 3'd2;
  assign accum_rd_addr = accum_rd_en ? rd_idx : '0;
  assign out_valid = occ != 2'd0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign new_addr = base_q + wr_idx;
  // an arriving row goes straight to the head when the head is empty or leaving now
  assign load_head = inflight && (occ == 2'd0 || (occ == 2'd1 && pop));
  assign flush_empty = !inflight && (occ == 2'd0 || (occ == 2'd1 && pop));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      num_q <= '0;
      base_q <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      inflight <= 1'b0;
      occ <= '0;
      out_data <= '0;
      out_addr <= '0;
      data1 <= '0;
      addr1 <= '0;
    end else begin
      inflight <= accum_rd_en;
      occ <= occ + 2'(inflight) - 2'(pop);
      if (accum_rd_en) rd_idx <= rd_idx + ADDR_WIDTH'(1);
      if (inflight) wr_idx <= wr_idx + ADDR_WIDTH'(1);
      if (load_head) begin
        out_data <= accum_rd_data;
        out_addr <= new_addr;
      end else if (pop && occ == 2'd2) begin
        out_data <= data1;
        out_addr <= addr1;
      end
      if (inflight && !load_head) begin
        data1 <= accum_rd_data;
        addr1 <= new_addr;
      end
      case (state)
        IDLE:
          if (start) begin
            num_q <= num_in;
            base_q <= out_base_addr;
            rd_idx <= '0;
            wr_idx <= '0;
            state <= num_in != '0 ? READ : DONE;
          end
        READ: if (accum_rd_en && rd_idx == num_q - ADDR_WIDTH'(1)) state <= FLUSH;
        FLUSH: if (flush_empty) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  assert property (@(posedge clk) disable iff (!rstn) !(inflight && !pop && occ == 2'd2));
endmodule
